// File: rtl/ram_scan_reader_if.sv
// ram_scan_reader_if: read port between the scan reader and the on-chip sdram32 RAM
interface ram_scan_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_wren;
  logic [DATA_WIDTH-1:0] ram_q;
  modport master (output ram_address, output ram_wren, input ram_q);
  modport slave (input ram_address, input ram_wren, output ram_q);
endinterface

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: steps through RAM words on a debounced press or a dwell timer and presents each word
module ram_scan_reader #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_LATENCY    = 2,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  reset,
  input  logic                  step_btn,
  input  logic                  auto_en,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  ram_scan_reader_if.master     ram,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  word_valid,
  output logic                  busy
);
  localparam int WW = $clog2(READ_LATENCY + 1);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, WAIT = 2'd2;
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WW-1:0]         wait_cnt;
  logic [DW-1:0]         dwell_cnt;
  logic [BW-1:0]         db_cnt;
  logic                  db_level, db_prev, man_ev, auto_ev, step, dwell_hit, db_hit;
  assign ram.ram_address = addr;
  assign ram.ram_wren    = 1'b0;
  assign busy      = state != IDLE && !reset;
  assign step      = state == IDLE && (man_ev || (auto_ev && auto_en));
  assign dwell_hit = dwell_cnt == DW'(DWELL_CYCLES - 1);
  assign db_hit    = db_cnt == BW'(DEBOUNCE_CYCLES - 1);
  // debounce the raw button and emit a registered one-cycle pulse on its rising edge
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
      man_ev   <= 1'b0;
    end else begin
      db_prev  <= db_level;
      man_ev   <= db_level & ~db_prev;
      db_cnt   <= (step_btn == db_level || db_hit) ? '0 : db_cnt + BW'(1);
      db_level <= (step_btn != db_level && db_hit) ? step_btn : db_level;
    end
  end
  // dwell timer counts only while idle with auto enabled and raises a registered step pulse
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      dwell_cnt <= '0;
      auto_ev   <= 1'b0;
    end else begin
      auto_ev   <= auto_en && state == IDLE && !step && dwell_hit;
      dwell_cnt <= (!auto_en || state != IDLE || step || dwell_hit) ? '0 : dwell_cnt + DW'(1);
    end
  end
  // read sequencer: advance address on a step, then wait out the RAM latency and capture
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state      <= INIT;
      addr       <= start_addr;
      wait_cnt   <= '0;
      word_out   <= '0;
      word_addr  <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (state == INIT) begin
        state    <= WAIT;
        wait_cnt <= WW'(1);
      end else if (state == IDLE) begin
        if (step) begin
          addr     <= addr + ADDR_WIDTH'(1);
          state    <= WAIT;
          wait_cnt <= WW'(1);
        end
      end else if (wait_cnt == WW'(READ_LATENCY)) begin
        word_out   <= ram.ram_q;
        word_addr  <= addr;
        word_valid <= 1'b1;
        state      <= IDLE;
      end else begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end
endmodule
